// File: rtl/rvdffe.sv
// Enable-qualified register with a synchronous active-high reset.
// It has a gated build with a latch-based clock gate per 32-bit slice and an ungated build.
module rvdffe #(
    parameter int WIDTH = 1,
    parameter int SHORT = 0
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             scan_mode,
    output logic [WIDTH-1:0] dout
);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("rvdffe: WIDTH must be >= 1");
        end

        if (SHORT != 0) begin : g_short
            logic [WIDTH-1:0] r_q;
            logic             w_unused_scan;

            assign w_unused_scan = scan_mode;

            always_ff @(posedge clk) begin
                r_q <= rst_l ? '0 : (en ? din : r_q);
            end

            assign dout = r_q;
        end else begin : g_gated
            localparam int NSL = (WIDTH + 31) / 32;

            // Reset is folded into the gate enable so it lands while en=0.
            logic w_gate_en;
            assign w_gate_en = en | scan_mode | rst_l;

            for (genvar s = 0; s < NSL; s++) begin : g_slice
                localparam int LO = s * 32;
                localparam int SW = (WIDTH - LO > 32) ? 32 : WIDTH - LO;

                logic          r_en_lat;
                logic          w_gclk;
                logic [SW-1:0] r_q;

                always_latch begin
                    if (!clk) r_en_lat <= w_gate_en;
                end

                assign w_gclk = clk & r_en_lat;

                always_ff @(posedge w_gclk) begin
                    if (rst_l) r_q <= '0;
                    else       r_q <= din[LO +: SW];
                end

                assign dout[LO +: SW] = r_q;
            end
        end
    endgenerate

endmodule

// File: tb/tb_rvdffe.sv
// Randomised self-checking bench for rvdffe in the gated and ungated builds.
// The bench covers widths 32 and 70 and compares the outputs against a behavioural model on every cycle.
module tb_rvdffe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_l     = 1'b0;
    logic        en        = 1'b0;
    logic        scan_mode = 1'b0;
    logic [69:0] din       = '0;

    logic [31:0] d_g32;
    logic [31:0] d_u32;
    logic [69:0] d_g70;
    logic [69:0] d_u70;

    rvdffe #(.WIDTH(32), .SHORT(0)) u_g32 (
        .clk(clk), .rst_l(rst_l), .en(en), .din(din[31:0]),
        .scan_mode(scan_mode), .dout(d_g32));
    rvdffe #(.WIDTH(32), .SHORT(1)) u_u32 (
        .clk(clk), .rst_l(rst_l), .en(en), .din(din[31:0]),
        .scan_mode(scan_mode), .dout(d_u32));
    rvdffe #(.WIDTH(70), .SHORT(0)) u_g70 (
        .clk(clk), .rst_l(rst_l), .en(en), .din(din),
        .scan_mode(scan_mode), .dout(d_g70));
    rvdffe #(.WIDTH(70), .SHORT(1)) u_u70 (
        .clk(clk), .rst_l(rst_l), .en(en), .din(din),
        .scan_mode(scan_mode), .dout(d_u70));

    localparam logic [69:0] M32 = 70'h00_0000_0000_FFFF_FFFF;
    localparam logic [69:0] M70 = 70'h3F_FFFF_FFFF_FFFF_FFFF;

    int total = 0;
    int bad   = 0;

    // Model: index 0..3 = g32, u32, g70, u70; v marks a defined value
    logic [69:0] m [4];
    bit          v [4];

    function automatic logic [69:0] dval(input int k);
        case (k)
            0:       return {38'd0, d_g32};
            1:       return {38'd0, d_u32};
            2:       return d_g70;
            default: return d_u70;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [69:0] act,
                       input logic [69:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++)
            if (v[k]) chk($sformatf("model_dut%0d", k), dval(k), m[k]);
    end

    always @(posedge clk) begin
        if (!rst_l)
            assert (!$isunknown(en)) else $error("en is X outside reset");
    end

    task automatic tick(input logic r, input logic e,
                        input logic [69:0] d, input logic s);
        rst_l = r; en = e; din = d; scan_mode = s;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            bit          shrt;
            logic [69:0] mk;
            shrt = (k % 2) == 1;
            mk   = (k < 2) ? M32 : M70;
            if (r) begin
                m[k] = '0;
                v[k] = 1'b1;
            end else if (e || (s && !shrt)) begin
                m[k] = d & mk;
            end
        end
        #1;
    endtask

    // en pulses only while clk is high; it is 0 at every rising edge
    task automatic glitch(input logic [69:0] d);
        rst_l = 1'b0; en = 1'b0; din = d; scan_mode = 1'b0;
        @(posedge clk);
        #1 en = 1'b1;
        #1 en = 1'b0;
        #1 en = 1'b1;
        #1 en = 1'b0;
    endtask

    initial begin
        logic [95:0] rr;
        for (int k = 0; k < 4; k++) begin
            m[k] = '0;
            v[k] = 1'b0;
        end

        tick(1'b1, 1'b0, '0, 1'b0);
        chk("por_reset_g32", {38'd0, d_g32}, 70'd0);
        chk("por_reset_u70", d_u70, 70'd0);

        tick(1'b0, 1'b1, 70'hDEADBEEF, 1'b0);
        chk("preload", {38'd0, d_g32}, 70'hDEADBEEF);
        tick(1'b1, 1'b1, M70, 1'b0);
        chk("reset_wins_g32", {38'd0, d_g32}, 70'd0);
        chk("reset_wins_u32", {38'd0, d_u32}, 70'd0);

        tick(1'b0, 1'b1, 70'h12345678, 1'b0);
        chk("load_g32", {38'd0, d_g32}, 70'h12345678);
        repeat (10) tick(1'b0, 1'b0, 70'hA5A5A5A5, 1'b0);
        chk("hold_g32", {38'd0, d_g32}, 70'h12345678);
        chk("hold_u32", {38'd0, d_u32}, 70'h12345678);

        for (int i = 1; i <= 3; i++) begin
            tick(1'b0, 1'b1, 70'(i), 1'b0);
            chk($sformatf("b2b_%0d", i), {38'd0, d_g32}, 70'(i));
        end

        repeat (4) glitch(70'h3_1234_5678_9ABC_DEF0);
        chk("glitch_g32", {38'd0, d_g32}, 70'd3);
        chk("glitch_g70", d_g70, 70'd3);

        tick(1'b0, 1'b0, 70'h0000FFFF, 1'b1);
        chk("scan_g32", {38'd0, d_g32}, 70'h0000FFFF);
        chk("scan_u32", {38'd0, d_u32}, 70'd3);
        chk("scan_g70", d_g70, 70'h0000FFFF);
        chk("scan_u70", d_u70, 70'd3);

        tick(1'b0, 1'b1, M70, 1'b0);
        chk("wide_load_g70", d_g70, M70);
        chk("wide_load_u70", d_u70, M70);
        repeat (3) tick(1'b0, 1'b0, '0, 1'b0);
        chk("wide_hold_g70", d_g70, M70);
        tick(1'b1, 1'b0, '0, 1'b0);
        chk("wide_reset_g70", d_g70, 70'd0);
        chk("wide_reset_u70", d_u70, 70'd0);

        repeat (400) begin
            rr = {$urandom, $urandom, $urandom};
            if ($urandom_range(0, 9) == 0)
                glitch(rr[69:0]);
            else
                tick($urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
                     rr[69:0], $urandom_range(0, 7) == 0);
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
